// File: rtl/roba_operand_prep.sv
// Operand preparation for the RoBA approximate multiplier: finds each operand's
// leading one, rounds it to the nearest power of two (ties up) and hands
// A, B, Ar, Br and the rounded exponents to the multiplier through a
// two-stage valid/ready pipeline.
module roba_operand_prep #(
  parameter int unsigned A_BW = 32,
  parameter int unsigned B_BW = 32,
  parameter int unsigned KA_W = $clog2(A_BW + 1),
  parameter int unsigned KB_W = $clog2(B_BW + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [A_BW-1:0]   a_i,
  input  logic [B_BW-1:0]   b_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [A_BW-1:0]   a_o,
  output logic [B_BW-1:0]   b_o,
  output logic [A_BW:0]     ar_o,
  output logic [B_BW:0]     br_o,
  output logic [KA_W-1:0]   ka_o,
  output logic [KB_W-1:0]   kb_o,
  output logic              zero_o
);

  // Stage 1 state: operands, leading-one index, round bit, zero flags
  logic              s1_valid_q;
  logic [A_BW-1:0]   s1_a_q;
  logic [B_BW-1:0]   s1_b_q;
  logic [KA_W-1:0]   s1_ka_q, s1_ka_d;
  logic [KB_W-1:0]   s1_kb_q, s1_kb_d;
  logic              s1_ra_q, s1_ra_d;
  logic              s1_rb_q, s1_rb_d;
  logic              s1_za_q, s1_zb_q;

  // Stage 2 (output) state
  logic              s2_valid_q;
  logic [A_BW-1:0]   s2_a_q;
  logic [B_BW-1:0]   s2_b_q;
  logic [A_BW:0]     s2_ar_q, s2_ar_d;
  logic [B_BW:0]     s2_br_q, s2_br_d;
  logic [KA_W-1:0]   s2_ka_q, s2_ka_d;
  logic [KB_W-1:0]   s2_kb_q, s2_kb_d;
  logic              s2_zero_q;

  logic              s1_adv;
  logic              s2_adv;
  logic [KA_W-1:0]   ea;
  logic [KB_W-1:0]   eb;

  // Pipeline advance: a stage moves when it is empty or its successor moves
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Leading-one index and the bit just below it (the round bit)
  always_comb begin
    s1_ka_d = '0;
    s1_ra_d = 1'b0;
    s1_kb_d = '0;
    s1_rb_d = 1'b0;
    for (int unsigned i = 1; i < A_BW; i++) begin
      if (a_i[i]) begin
        s1_ka_d = KA_W'(i);
        s1_ra_d = a_i[i-1];
      end
    end
    for (int unsigned j = 1; j < B_BW; j++) begin
      if (b_i[j]) begin
        s1_kb_d = KB_W'(j);
        s1_rb_d = b_i[j-1];
      end
    end
  end

  // Rounded exponent and power-of-two value; a zero operand yields Ar=0, e=0
  always_comb begin
    ea      = s1_ka_q + KA_W'(s1_ra_q);
    eb      = s1_kb_q + KB_W'(s1_rb_q);
    s2_ar_d = s1_za_q ? '0 : ((A_BW+1)'(1) << ea);
    s2_br_d = s1_zb_q ? '0 : ((B_BW+1)'(1) << eb);
    s2_ka_d = s1_za_q ? '0 : ea;
    s2_kb_d = s1_zb_q ? '0 : eb;
  end

  // Stage 1 register: capture an accepted pair
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ka_q    <= '0;
      s1_kb_q    <= '0;
      s1_ra_q    <= 1'b0;
      s1_rb_q    <= 1'b0;
      s1_za_q    <= 1'b0;
      s1_zb_q    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_a_q  <= a_i;
        s1_b_q  <= b_i;
        s1_ka_q <= s1_ka_d;
        s1_kb_q <= s1_kb_d;
        s1_ra_q <= s1_ra_d;
        s1_rb_q <= s1_rb_d;
        s1_za_q <= (a_i == '0);
        s1_zb_q <= (b_i == '0);
      end
    end
  end

  // Stage 2 register: output holding register, frozen under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_b_q     <= '0;
      s2_ar_q    <= '0;
      s2_br_q    <= '0;
      s2_ka_q    <= '0;
      s2_kb_q    <= '0;
      s2_zero_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_a_q    <= s1_a_q;
        s2_b_q    <= s1_b_q;
        s2_ar_q   <= s2_ar_d;
        s2_br_q   <= s2_br_d;
        s2_ka_q   <= s2_ka_d;
        s2_kb_q   <= s2_kb_d;
        s2_zero_q <= s1_za_q || s1_zb_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign a_o       = s2_a_q;
  assign b_o       = s2_b_q;
  assign ar_o      = s2_ar_q;
  assign br_o      = s2_br_q;
  assign ka_o      = s2_ka_q;
  assign kb_o      = s2_kb_q;
  assign zero_o    = s2_zero_q;

endmodule

// File: tb/tb_roba_operand_prep.sv
// Bench for roba_operand_prep at 8-bit operands: directed table, backpressure
// stream, random handshake traffic against a scoreboard, and mid-flight reset.
module tb_roba_operand_prep;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] ar;
    logic [3:0] ka;
    logic [8:0] br;
    logic [3:0] kb;
    logic       z;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] a_o;
  logic [7:0] b_o;
  logic [8:0] ar_o;
  logic [8:0] br_o;
  logic [3:0] ka_o;
  logic [3:0] kb_o;
  logic       zero_o;

  int   n_vec;
  int   n_err;
  int   n_rx;
  rec_t exp_q[$];
  bit   stall_prev;
  rec_t held;
  rec_t tbl[10];

  roba_operand_prep #(.A_BW(8), .B_BW(8), .KA_W(4), .KB_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_i       (a_i),
    .b_i       (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_o       (a_o),
    .b_o       (b_o),
    .ar_o      (ar_o),
    .br_o      (br_o),
    .ka_o      (ka_o),
    .kb_o      (kb_o),
    .zero_o    (zero_o)
  );

  always #5 clk = ~clk;

  // Nearest power of two by direct comparison against 1.5 * floor-power
  function automatic void rnd(input logic [7:0] v, output logic [8:0] ar, output logic [3:0] e);
    int p;
    int k;
    p = 1;
    k = 0;
    if (v == 8'd0) begin
      ar = 9'd0;
      e  = 4'd0;
    end else begin
      while (p * 2 <= int'(v)) begin
        p = p * 2;
        k = k + 1;
      end
      if (2 * int'(v) >= 3 * p) begin
        p = p * 2;
        k = k + 1;
      end
      ar = 9'(p);
      e  = 4'(k);
    end
  endfunction

  function automatic rec_t model(input logic [7:0] a, input logic [7:0] b);
    rec_t r;
    logic [8:0] t_ar;
    logic [3:0] t_e;
    r.a = a;
    r.b = b;
    rnd(a, t_ar, t_e);
    r.ar = t_ar;
    r.ka = t_e;
    rnd(b, t_ar, t_e);
    r.br = t_ar;
    r.kb = t_e;
    r.z  = (a == 8'd0) || (b == 8'd0);
    return r;
  endfunction

  function automatic rec_t mk(input int a, input int b, input int ar, input int ka,
                              input int br, input int kb, input int z);
    rec_t r;
    r.a  = 8'(a);
    r.b  = 8'(b);
    r.ar = 9'(ar);
    r.ka = 4'(ka);
    r.br = 9'(br);
    r.kb = 4'(kb);
    r.z  = 1'(z);
    return r;
  endfunction

  function automatic rec_t dut_rec();
    rec_t r;
    r.a  = a_o;
    r.b  = b_o;
    r.ar = ar_o;
    r.ka = ka_o;
    r.br = br_o;
    r.kb = kb_o;
    r.z  = zero_o;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input rec_t e, input string tag);
    chk({tag, "_a"},    int'(a_o),    int'(e.a));
    chk({tag, "_b"},    int'(b_o),    int'(e.b));
    chk({tag, "_ar"},   int'(ar_o),   int'(e.ar));
    chk({tag, "_ka"},   int'(ka_o),   int'(e.ka));
    chk({tag, "_br"},   int'(br_o),   int'(e.br));
    chk({tag, "_kb"},   int'(kb_o),   int'(e.kb));
    chk({tag, "_zero"}, int'(zero_o), int'(e.z));
  endtask

  // One cycle of scoreboarded traffic; caller has set inputs and settled #1
  task automatic tick(output bit fired);
    rec_t cur;
    rec_t e;
    cur = dut_rec();
    if (stall_prev) begin
      chk("hold_valid", int'(out_valid), 1);
      cmp_out(held, "hold");
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL extra_out: got pair a=%0d b=%0d, required no output", a_o, b_o);
      end else begin
        e = exp_q.pop_front();
        cmp_out(e, "data");
        n_rx++;
      end
    end
    stall_prev = out_valid && !out_ready;
    held       = cur;
    fired      = in_valid && in_ready;
    if (fired) exp_q.push_back(model(a_i, b_i));
    @(negedge clk);
  endtask

  // Single pair through an idle pipeline: exact latency 2 and field values
  task automatic shot(input rec_t e, input string tag);
    in_valid  = 1'b1;
    a_i       = e.a;
    b_i       = e.b;
    out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, int'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, int'(out_valid), 1);
    cmp_out(e, tag);
    @(negedge clk);
  endtask

  initial begin
    bit   fired;
    int   sent;
    bit   have;
    logic [7:0] pa;
    logic [7:0] pb;

    clk        = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a_i        = 8'd0;
    b_i        = 8'd0;
    n_vec      = 0;
    n_err      = 0;
    n_rx       = 0;
    stall_prev = 1'b0;
    held       = '0;

    tbl[0] = mk( 96,  80, 128, 7,  64, 6, 0);
    tbl[1] = mk(255,   3, 256, 8,   4, 2, 0);
    tbl[2] = mk(  1,   2,   1, 0,   2, 1, 0);
    tbl[3] = mk(  0,  77,   0, 0,  64, 6, 1);
    tbl[4] = mk(  0,   0,   0, 0,   0, 0, 1);
    tbl[5] = mk(  5,   6,   4, 2,   8, 3, 0);
    tbl[6] = mk(128, 192, 128, 7, 256, 8, 0);
    tbl[7] = mk(191,  12, 128, 7,  16, 4, 0);
    tbl[8] = mk( 11,   1,   8, 3,   1, 0, 0);
    tbl[9] = mk(254,   0, 256, 8,   0, 0, 1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready),  1);
    cmp_out('0, "rst");
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) shot(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back stream of 10 with out_ready low for cycles 3..6
    sent       = 0;
    n_rx       = 0;
    stall_prev = 1'b0;
    for (int cyc = 0; cyc < 60 && n_rx < 10; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 10);
      a_i       = 8'(17 * sent + 3);
      b_i       = 8'(255 - 13 * sent);
      #1;
      if (cyc >= 3 && cyc <= 6) chk("stall_in_ready", int'(in_ready), 0);
      if (cyc >= 7) chk("rate_out_valid", int'(out_valid), 1);
      tick(fired);
      if (fired) sent++;
    end
    in_valid = 1'b0;
    chk("stream_rx", n_rx, 10);
    chk("stream_left", exp_q.size(), 0);

    // Random valid/ready traffic, 1000 pairs
    sent = 0;
    n_rx = 0;
    have = 1'b0;
    pa   = 8'd0;
    pb   = 8'd0;
    for (int cyc = 0; cyc < 20000 && n_rx < 1000; cyc++) begin
      if (!have) begin
        pa   = 8'($urandom);
        pb   = 8'($urandom);
        if ($urandom_range(7) == 0) pa = 8'd0;
        if ($urandom_range(7) == 0) pb = 8'd255;
        have = 1'b1;
      end
      out_ready = ($urandom_range(3) != 0);
      in_valid  = (sent < 1000) && ($urandom_range(2) != 0);
      a_i       = pa;
      b_i       = pb;
      #1;
      tick(fired);
      if (fired) begin
        sent++;
        have = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("rand_rx", n_rx, 1000);
    chk("rand_left", exp_q.size(), 0);

    // Reset with two pairs in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_i       = 8'd200;
    b_i       = 8'd33;
    @(negedge clk);
    a_i = 8'd7;
    b_i = 8'd9;
    #1;
    chk("fill_in_ready", int'(in_ready), 1);
    @(negedge clk);
    chk("fill_out_valid", int'(out_valid), 1);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_in_ready",  int'(in_ready),  1);
    cmp_out('0, "mrst");
    exp_q.delete();
    stall_prev = 1'b0;
    shot(mk(48, 40, 64, 6, 32, 5, 0), "post_rst");
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stale_out_valid", int'(out_valid), 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
